// File: rtl/mc_control_ws.sv
// mc_control_ws: multi-cycle control FSM with memory wait states, timeout trap and
// a retired-instruction counter.
module mc_control_ws #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4,
    parameter int RET_W       = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [6:0]       input_control,
    input  logic             mem_ready,
    output logic             output_control_Branch,
    output logic             output_control_IoD,
    output logic             output_control_IRWrite,
    output logic             output_control_Mem2Reg,
    output logic             output_control_MemR,
    output logic             output_control_MemW,
    output logic             output_control_PCWrite,
    output logic             output_control_RegWrite,
    output logic [1:0]       output_control_PCSrc,
    output logic [1:0]       output_control_ALUSrcA,
    output logic [1:0]       output_control_ALUSrcB,
    output logic [1:0]       output_control_BranchType,
    output logic [3:0]       output_control_ALUOp,
    output logic [3:0]       output_control_current_state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [RET_W-1:0] retired
);
    typedef enum logic [3:0] {
        FETCH, DECODE, RTYPE, RITYPE, RTYPEEND, LW1, LW2, SW,
        JALR, BRANCH, BRANCH2, JAL, TRAP
    } state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_next;
    logic [1:0]         cause_next;
    logic               mem_state, timeout, retire;
    logic [3:0]         funct, alu_f;
    logic [2:0]         opcode;

    assign funct  = input_control[6:3];
    assign opcode = input_control[2:0];
    assign alu_f  = (funct <= 4'd8) ? funct :
                    (funct == 4'd9 || funct == 4'd10) ? 4'b1001 :
                    (funct == 4'd12) ? 4'b1100 : 4'b1111;

    assign mem_state = state == FETCH || state == LW1 || state == SW;
    assign timeout   = MEM_TIMEOUT != 0 && !mem_ready && wait_cnt == CNT_W'(MEM_TIMEOUT);
    assign output_control_current_state = state;

    always_comb begin
        output_control_Branch     = 1'b0;
        output_control_IoD        = 1'b0;
        output_control_IRWrite    = 1'b0;
        output_control_Mem2Reg    = 1'b0;
        output_control_MemR       = 1'b0;
        output_control_MemW       = 1'b0;
        output_control_PCWrite    = 1'b0;
        output_control_RegWrite   = 1'b0;
        output_control_PCSrc      = 2'd0;
        output_control_ALUSrcA    = 2'd0;
        output_control_ALUSrcB    = 2'd0;
        output_control_BranchType = 2'd0;
        output_control_ALUOp      = 4'b1111;
        trap                      = 1'b0;
        next_state                = FETCH;
        case (state)
            FETCH: begin
                output_control_MemR    = 1'b1;
                output_control_ALUSrcB = 2'd1;
                output_control_ALUOp   = 4'b0000;
                output_control_IRWrite = mem_ready;
                output_control_PCWrite = mem_ready;
                next_state = mem_ready ? DECODE : timeout ? TRAP : FETCH;
            end
            DECODE: next_state = opcode == 3'd0 ? RTYPE :
                                 opcode == 3'd1 ? (funct == 4'b1011 ? JALR :
                                                   funct >= 4'b1100 ? BRANCH : RITYPE) :
                                 opcode == 3'd2 ? RITYPE :
                                 opcode == 3'd3 ? FETCH :
                                 opcode == 3'd4 ? JAL : TRAP;
            RTYPE: begin
                output_control_ALUOp   = alu_f;
                output_control_ALUSrcA = 2'd2;
                next_state = RTYPEEND;
            end
            RITYPE: begin
                output_control_ALUOp   = alu_f;
                output_control_ALUSrcA = 2'd2;
                output_control_ALUSrcB = 2'd2;
                next_state = funct == 4'b1001 ? LW1 : funct == 4'b1010 ? SW : RTYPEEND;
            end
            RTYPEEND: output_control_RegWrite = 1'b1;
            LW1: begin
                output_control_IoD  = 1'b1;
                output_control_MemR = 1'b1;
                next_state = mem_ready ? LW2 : timeout ? TRAP : LW1;
            end
            LW2: begin
                output_control_Mem2Reg  = 1'b1;
                output_control_RegWrite = 1'b1;
            end
            SW: begin
                output_control_IoD  = 1'b1;
                output_control_MemW = 1'b1;
                next_state = mem_ready ? FETCH : timeout ? TRAP : SW;
            end
            JALR: begin
                output_control_ALUOp    = 4'b0111;
                output_control_ALUSrcA  = 2'd3;
                output_control_ALUSrcB  = 2'd1;
                output_control_RegWrite = 1'b1;
            end
            BRANCH: begin
                output_control_ALUOp      = 4'b1001;
                output_control_ALUSrcB    = 2'd2;
                output_control_Branch     = 1'b1;
                output_control_BranchType = funct[1:0];
                next_state = BRANCH2;
            end
            BRANCH2: begin
                output_control_ALUOp      = 4'b0001;
                output_control_ALUSrcA    = 2'd2;
                output_control_Branch     = 1'b1;
                output_control_BranchType = funct[1:0];
                output_control_PCSrc      = 2'd1;
                output_control_PCWrite    = 1'b1;
            end
            JAL: begin
                output_control_ALUOp   = 4'b0111;
                output_control_ALUSrcA = 2'd3;
                output_control_ALUSrcB = 2'd1;
                output_control_PCWrite = 1'b1;
            end
            TRAP: begin
                output_control_PCSrc   = 2'd2;
                output_control_PCWrite = 1'b1;
                trap = 1'b1;
            end
            default: next_state = FETCH;
        endcase
    end

    // The counter only survives a cycle that stalls without leaving the memory state.
    assign wait_cnt_next = (mem_state && !mem_ready && next_state == state) ? wait_cnt + CNT_W'(1) : '0;
    assign cause_next = (next_state != TRAP || state == TRAP) ? trap_cause :
                        state == DECODE ? 2'd1 : state == FETCH ? 2'd2 : 2'd3;
    assign retire = state == RTYPEEND || state == LW2 || state == JALR || state == BRANCH2 ||
                    state == JAL || (state == SW && mem_ready) || (state == DECODE && opcode == 3'd3);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= FETCH;
            wait_cnt   <= '0;
            trap_cause <= 2'd0;
            retired    <= '0;
        end else begin
            state      <= next_state;
            wait_cnt   <= wait_cnt_next;
            trap_cause <= cause_next;
            retired    <= retired + RET_W'(retire);
        end
    end
endmodule

// File: tb/tb_mc_control_ws.sv
// tb_mc_control_ws: randomized instruction stream with stall injection; a per-cycle
// expectation queue is drained by an independent negedge monitor.
module tb_mc_control_ws;
    localparam int TO = 15;
    localparam int RW = 4;

    typedef struct packed {
        logic [3:0]    st;
        logic          branch, iod, irw, m2r, memr, memw, pcw, rw;
        logic [1:0]    pcsrc, sa, sb, bt;
        logic [3:0]    aluop;
        logic          trap;
        logic [1:0]    cause;
        logic [RW-1:0] ret;
    } exp_t;

    logic          clk = 1'b0;
    logic          Reset;
    logic [6:0]    ic;
    logic          mem_ready;
    logic          branch, iod, irw, m2r, memr, memw, pcw, rw, trap;
    logic [1:0]    pcsrc, sa, sb, bt, cause;
    logic [3:0]    aluop, st;
    logic [RW-1:0] ret;
    exp_t          act;
    exp_t          exp_q[$];
    logic [1:0]    m_cause;
    logic [RW-1:0] m_ret;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    mc_control_ws #(.MEM_TIMEOUT(TO), .CNT_W(4), .RET_W(RW)) dut (
        .CLK(clk), .Reset(Reset), .input_control(ic), .mem_ready(mem_ready),
        .output_control_Branch(branch), .output_control_IoD(iod), .output_control_IRWrite(irw),
        .output_control_Mem2Reg(m2r), .output_control_MemR(memr), .output_control_MemW(memw),
        .output_control_PCWrite(pcw), .output_control_RegWrite(rw), .output_control_PCSrc(pcsrc),
        .output_control_ALUSrcA(sa), .output_control_ALUSrcB(sb), .output_control_BranchType(bt),
        .output_control_ALUOp(aluop), .output_control_current_state(st),
        .trap(trap), .trap_cause(cause), .retired(ret)
    );

    assign act = {st, branch, iod, irw, m2r, memr, memw, pcw, rw, pcsrc, sa, sb, bt, aluop, trap, cause, ret};

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, a, e);
        end
    endtask

    function automatic logic [3:0] alu_of(input logic [3:0] f);
        if (f <= 8) return f;
        if (f == 9 || f == 10) return 4'd9;
        if (f == 12) return 4'd12;
        return 4'd15;
    endfunction

    // Output table of each state, as the datapath should see it.
    function automatic exp_t expect_of(input int s, input logic mr);
        exp_t e;
        logic [3:0] f;
        f = ic[6:3];
        e = '0;
        e.aluop = 4'hF;
        e.st = 4'(s);
        e.cause = m_cause;
        e.ret = m_ret;
        case (s)
            0:  begin e.memr = 1; e.sb = 1; e.aluop = 0; e.irw = mr; e.pcw = mr; end
            2:  begin e.aluop = alu_of(f); e.sa = 2; end
            3:  begin e.aluop = alu_of(f); e.sa = 2; e.sb = 2; end
            4:  e.rw = 1;
            5:  begin e.iod = 1; e.memr = 1; end
            6:  begin e.m2r = 1; e.rw = 1; end
            7:  begin e.iod = 1; e.memw = 1; end
            8:  begin e.aluop = 7; e.sa = 3; e.sb = 1; e.rw = 1; end
            9:  begin e.aluop = 9; e.sb = 2; e.branch = 1; e.bt = f[1:0]; end
            10: begin e.aluop = 1; e.sa = 2; e.branch = 1; e.bt = f[1:0]; e.pcsrc = 1; e.pcw = 1; end
            11: begin e.aluop = 7; e.sa = 3; e.sb = 1; e.pcw = 1; end
            12: begin e.pcsrc = 2; e.pcw = 1; e.trap = 1; end
            default: ;
        endcase
        return e;
    endfunction

    // One clock cycle spent in state s; effects on cause/retired appear next cycle.
    task automatic step(input int s, input logic mr, input bit inc, input int ncause);
        mem_ready = mr;
        exp_q.push_back(expect_of(s, mr));
        @(posedge clk);
        #1;
        if (inc) m_ret = m_ret + 1'b1;
        if (ncause != 0) m_cause = 2'(ncause);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic mem_phase(input int s, input int stalls, input int tcause, input bit inc, output bit trapped);
        trapped = stalls > TO;
        for (int i = 0; i < stalls && i <= TO; i++)
            step(s, 1'b0, 1'b0, (i == TO) ? tcause : 0);
        if (trapped) step(12, rnd(), 1'b0, 0);
        else step(s, 1'b1, inc, 0);
    endtask

    task automatic run_instr(input logic [6:0] instr, input int fs, input int ds);
        bit t;
        int op, f;
        ic = instr;
        op = int'(instr[2:0]);
        f = int'(instr[6:3]);
        mem_phase(0, fs, 2, 1'b0, t);
        if (t) return;
        step(1, rnd(), op == 3, op >= 5 ? 1 : 0);
        if (op == 0) begin
            step(2, rnd(), 1'b0, 0);
            step(4, rnd(), 1'b1, 0);
        end else if (op == 1 && f == 11) step(8, rnd(), 1'b1, 0);
        else if (op == 1 && f >= 12) begin
            step(9, rnd(), 1'b0, 0);
            step(10, rnd(), 1'b1, 0);
        end else if (op == 1 || op == 2) begin
            step(3, rnd(), 1'b0, 0);
            if (f == 9) begin
                mem_phase(5, ds, 3, 1'b0, t);
                if (!t) step(6, rnd(), 1'b1, 0);
            end else if (f == 10) mem_phase(7, ds, 3, 1'b1, t);
            else step(4, rnd(), 1'b1, 0);
        end else if (op == 4) step(11, rnd(), 1'b1, 0);
        else if (op >= 5) step(12, rnd(), 1'b0, 0);
    endtask

    function automatic int rstall();
        int r;
        r = $urandom_range(0, 19);
        return r < 12 ? 0 : r < 17 ? $urandom_range(1, 3) : r == 17 ? TO : TO + 1;
    endfunction

    always @(negedge clk) begin
        if (!Reset) begin
            if (exp_q.size() == 0) chk("expectation_underflow", 64'd1, 64'd0);
            else chk($sformatf("cycle_outputs@%0t", $time), 64'(act), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        Reset = 1'b1;
        mem_ready = 1'b1;
        ic = '0;
        m_cause = '0;
        m_ret = '0;
        #3;
        chk("reset_state", 64'(st), 64'd0);
        chk("reset_memr", 64'(memr), 64'd1);
        chk("reset_srcb", 64'(sb), 64'd1);
        chk("reset_aluop", 64'(aluop), 64'd0);
        chk("reset_irwrite", 64'(irw), 64'd1);
        chk("reset_pcwrite", 64'(pcw), 64'd1);
        chk("reset_retired", 64'(ret), 64'd0);
        chk("reset_cause", 64'(cause), 64'd0);
        mem_ready = 1'b0;
        #1;
        chk("reset_irwrite_lo", 64'(irw), 64'd0);
        @(posedge clk);
        #1;
        Reset = 1'b0;
        run_instr(7'b0000_000, 0, 0);
        run_instr(7'b1001_001, 0, 3);
        run_instr(7'b0000_101, 0, 0);
        run_instr(7'b0000_000, TO + 1, 0);
        run_instr(7'b0000_000, TO, 0);
        run_instr(7'b1101_001, 0, 0);
        run_instr(7'b1010_010, 0, TO + 1);
        run_instr(7'b1001_010, 1, TO);
        for (int i = 0; i < 200; i++) begin
            logic [6:0] r;
            int op;
            op = $urandom_range(0, 9);
            r[2:0] = 3'(op > 7 ? 1 : op);
            r[6:3] = 4'($urandom_range(0, 15));
            run_instr(r, rstall(), rstall());
        end
        ic = 7'b1010_010;
        step(0, 1'b1, 1'b0, 0);
        step(1, rnd(), 1'b0, 0);
        step(3, rnd(), 1'b0, 0);
        step(7, 1'b0, 1'b0, 0);
        chk("sw_wait_memw", 64'(memw), 64'd1);
        #1;
        Reset = 1'b1;
        #1;
        chk("abort_memw", 64'(memw), 64'd0);
        chk("abort_state", 64'(st), 64'd0);
        chk("abort_retired", 64'(ret), 64'd0);
        chk("abort_cause", 64'(cause), 64'd0);
        @(posedge clk);
        #1;
        Reset = 1'b0;
        m_ret = '0;
        m_cause = '0;
        for (int i = 0; i < 20; i++) run_instr(7'b0000_000, $urandom_range(0, 1), 0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
